// File: rtl/psum_diff_if.sv
// psum_diff_if: stream bundle for the running-sum differencer.
// The "s" side carries running partial sums into the block; the "m" side
// carries recovered samples out. The master modport drives input words and
// consumes output words. The slave modport is the differencer itself.
interface psum_diff_if #(
    parameter int DWIDTH = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last
    );
endinterface

// File: rtl/psum_diff.sv
// psum_diff: recovers individual samples from a stream of running partial
// sums. Each accepted word produces (word - previous word), and the history
// restarts at every frame boundary of FRAME_LEN words. The output is a
// single-entry register stage with valid/ready, so one word moves per cycle.
// Overflow of the difference sets a sticky ovf flag.
// Optional feature: define PSUM_DIFF_SAT_EN to clamp overflowing differences
// to the signed range. By default, the wrapped DWIDTH-bit result is output.
module psum_diff #(
    parameter int DWIDTH    = 16,
    parameter int FRAME_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    psum_diff_if.slave  bus,
    output logic        ovf
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic              m_valid_q, m_valid_d;
    logic [DWIDTH-1:0] m_data_q,  m_data_d;
    logic              m_last_q,  m_last_d;
    logic              ovf_q,     ovf_d;
    logic [DWIDTH-1:0] prev_q,    prev_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic                     accept;
    logic                     frame_end;
    logic                     diff_ovf;
    logic signed [DWIDTH:0]   diff_wide;

    // Map the one-bit-wider difference to the output width. It either
    // clamps or wraps, depending on the build option.
    function automatic logic [DWIDTH-1:0] fit_result(input logic signed [DWIDTH:0] wide);
`ifdef PSUM_DIFF_SAT_EN
        if (wide[DWIDTH] != wide[DWIDTH-1]) begin
            // Sign bit of the wide value tells which rail was crossed.
            return wide[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                : {1'b0, {(DWIDTH-1){1'b1}}};
        end
        return wide[DWIDTH-1:0];
`else
        return wide[DWIDTH-1:0];
`endif
    endfunction

    // Input is taken only when the output slot is free or draining, never during abort or reset.
    assign bus.s_ready = rst_n && !clr && (!m_valid_q || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign ovf         = ovf_q;

    // Difference, overflow detection and next-state for the output stage and frame history.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        ovf_d     = ovf_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;

        // prev_q is already zero at frame position 0, so no special case is needed here.
        diff_wide = $signed({bus.s_data[DWIDTH-1], bus.s_data})
                  - $signed({prev_q[DWIDTH-1], prev_q});
        diff_ovf  = diff_wide[DWIDTH] ^ diff_wide[DWIDTH-1];
        frame_end = (cnt_q == LAST_IDX);

        if (clr) begin
            // Abort wins over everything: the pending word is dropped and the frame restarts.
            m_valid_d = 1'b0;
            prev_d    = '0;
            cnt_d     = '0;
        end else if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = fit_result(diff_wide);
            m_last_d  = frame_end;
            ovf_d     = ovf_q | diff_ovf;
            prev_d    = frame_end ? '0 : bus.s_data;
            cnt_d     = frame_end ? '0 : cnt_q + CNT_W'(1);
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset that clears data and control alike.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
            prev_q    <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            ovf_q     <= ovf_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_psum_diff.sv
// tb_psum_diff: directed scenarios followed by randomized traffic. The
// reference is a transaction-level model: a queue of expected output words
// computed with integer arithmetic from each accepted input.
module tb_psum_diff;

    localparam int DW = 16;
    localparam int FL = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic ovf;

    psum_diff_if #(.DWIDTH(DW)) bus ();

    psum_diff #(.DWIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];

    logic [DW-1:0] m_prev;
    int            m_cnt;
    logic          m_ovf;
    logic          rst_seen;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Expected output word for one accepted input, from plain integer arithmetic.
    function automatic logic [DW-1:0] ref_diff(input logic [DW-1:0] cur, input logic [DW-1:0] prv,
                                               output logic of);
        int r;
        r  = int'($signed(cur)) - int'($signed(prv));
        of = (r > 32767) || (r < -32768);
`ifdef PSUM_DIFF_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[DW-1:0];
    endfunction

    // One clock cycle: drive, check registered/combinational outputs, then advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic mr,
                        input logic c, input logic rn);
        logic  exp_rdy;
        logic  acc;
        logic  out;
        logic  of;
        word_t w;
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.m_ready = mr;
        clr         = c;
        rst_n       = rn;
        #1;
        exp_rdy = rn && !c && ((exp_q.size() == 0) || mr);
        check("s_ready", {31'd0, bus.s_ready}, {31'd0, exp_rdy});
        check("m_valid", {31'd0, bus.m_valid}, {31'd0, exp_q.size() != 0});
        check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
        if (rst_seen) begin
            check("rst_m_data", {16'd0, bus.m_data}, 32'd0);
            check("rst_m_last", {31'd0, bus.m_last}, 32'd0);
        end
        if (exp_q.size() != 0) begin
            check("m_data", {16'd0, bus.m_data}, {16'd0, exp_q[0].d});
            check("m_last", {31'd0, bus.m_last}, {31'd0, exp_q[0].l});
        end
        acc = v && exp_rdy;
        out = (exp_q.size() != 0) && mr;
        rst_seen = !rn;
        if (!rn) begin
            exp_q.delete();
            m_prev = '0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
        end else if (c) begin
            exp_q.delete();
            m_prev = '0;
            m_cnt  = 0;
        end else begin
            if (out) begin
                got_d.push_back(bus.m_data);
                got_l.push_back(bus.m_last);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                w.d = ref_diff(d, m_prev, of);
                w.l = (m_cnt == FL - 1);
                if (of) m_ovf = 1'b1;
                exp_q.push_back(w);
                if (w.l) begin
                    m_prev = '0;
                    m_cnt  = 0;
                end else begin
                    m_prev = d;
                    m_cnt  = m_cnt + 1;
                end
            end
        end
    endtask

    logic [DW-1:0] ovf_word;
    logic [DW-1:0] rd;
    int            sel;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        clr         = 1'b0;
        rst_n       = 1'b0;
        m_prev      = '0;
        m_cnt       = 0;
        m_ovf       = 1'b0;
        rst_seen    = 1'b0;
`ifdef PSUM_DIFF_SAT_EN
        ovf_word = 16'h8000;
`else
        ovf_word = 16'h7FFF;
`endif

        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

        // Frame of running sums, then the first word of the next frame.
        got_d.delete(); got_l.delete();
        step(1'b1, 16'd5,   1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd12,  1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd12,  1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd30,  1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd100, 1'b1, 1'b0, 1'b1);
        check("frame_w0", {16'd0, got_d[0]}, 32'd5);
        check("frame_w1", {16'd0, got_d[1]}, 32'd7);
        check("frame_w2", {16'd0, got_d[2]}, 32'd0);
        check("frame_w3", {16'd0, got_d[3]}, 32'd18);
        check("frame_l2", {31'd0, got_l[2]}, 32'd0);
        check("frame_l3", {31'd0, got_l[3]}, 32'd1);

        // Downstream stall for three cycles with input pending.
        step(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd7, 1'b1, 1'b0, 1'b1);
        check("next_frame_w0", {16'd0, got_d[4]}, 32'd100);
        check("next_frame_l0", {31'd0, got_l[4]}, 32'd0);

        // Negative overflow: 0x8000 after 0x0001.
        step(1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0,    1'b1, 1'b0, 1'b1);
        check("stall_w", {16'd0, got_d[5]}, 32'h0000FFA3);
        check("ovf_word", {16'd0, got_d[7]}, {16'd0, ovf_word});
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("word_count", got_d.size(), 32'd8);

        // Frame abort with a word pending; the frame count restarts afterwards.
        got_d.delete(); got_l.delete();
        step(1'b1, 16'd3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd4, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'd9,  1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd10, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd11, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd12, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0,  1'b1, 1'b0, 1'b1);
        check("clr_count", got_d.size(), 32'd5);
        check("clr_w1", {16'd0, got_d[1]}, 32'd9);
        check("clr_l3", {31'd0, got_l[3]}, 32'd0);
        check("clr_l4", {31'd0, got_l[4]}, 32'd1);

        // Reset mid-frame while an output word is pending.
        got_d.delete(); got_l.delete();
        step(1'b1, 16'd40, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0,  1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0,  1'b1, 1'b0, 1'b1);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        step(1'b1, 16'd50, 1'b1, 1'b0, 1'b1);
        step(1'b0, 16'd0,  1'b1, 1'b0, 1'b1);
        check("rst_count", got_d.size(), 32'd1);
        check("rst_pass", {16'd0, got_d[0]}, 32'd50);

        // Randomized traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: rd = 16'h7FFF;
                1: rd = 16'h8000;
                2: rd = 16'h0000;
                3: rd = 16'hFFFF;
                default: rd = 16'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 99) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_diff.md
PSUM_DIFF -- requirements
Module: psum_diff

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, sample and sum width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous frame abort: clears history and counter.
REQ-006 SHALL have port s_valid  input  1  input running-sum word valid.
REQ-007 SHALL have port s_ready  output  1  block accepts the input word this cycle.
REQ-008 SHALL have port s_data  input  DWIDTH  running partial sum, two's complement.
REQ-009 SHALL have port m_valid  output  1  output difference valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts the output word.
REQ-011 SHALL have port m_data  output  DWIDTH  recovered sample = s_data minus previous s_data.
REQ-012 SHALL have port m_last  output  1  marks the final sample of a frame.
REQ-013 SHALL have port ovf  output  1  sticky signed-overflow flag.

Function
REQ-014 SHALL assert s_ready = (!m_valid || m_ready) && !clr, combinationally.
REQ-015 SHALL accept the input on a cycle where s_valid && s_ready ("accept").
REQ-016 On accept, SHALL register m_data = s_data - prev, where prev = 0 for the first word of a frame and the previously accepted s_data otherwise; latency 1 cycle.
REQ-017 On accept, SHALL set prev to s_data and advance the frame counter; when the counter equals FRAME_LEN-1, SHALL set m_last=1 and wrap both counter and prev to 0.
REQ-018 SHALL hold m_valid, m_data and m_last stable while m_valid && !m_ready.
REQ-019 SHALL deassert m_valid after a cycle where m_valid && m_ready, with no new accept in that cycle; with a simultaneous accept, m_valid stays 1 and carries the new word (full throughput, one word per cycle).
REQ-020 SHALL compute the difference in DWIDTH+1 bits; a signed overflow is a result outside [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
REQ-021 SHALL set ovf on any accept that overflows; ovf clears only on reset.
REQ-022 When clr=1, SHALL zero prev and the counter, and drop m_valid; clr takes priority over accept and handshake in that cycle.
REQ-023 When FRAME_LEN=1, SHALL pass every word through unchanged (prev always 0) with m_last=1.

Reset
REQ-024 When rst_n=0 at a rising edge, SHALL clear m_valid, m_data, m_last, ovf, prev and the counter to 0.
REQ-025 While rst_n=0, SHALL drive s_ready=0.
REQ-026 Reset mid-frame SHALL discard any pending output word and restart at frame position 0.

Configuration
REQ-027 Macro PSUM_DIFF_SAT_EN, when defined, SHALL clamp overflowing results to 2^(DWIDTH-1)-1 or -2^(DWIDTH-1).
REQ-028 Without PSUM_DIFF_SAT_EN, SHALL output the wrapped DWIDTH-bit result.
REQ-029 In both configurations, ovf SHALL behave as in REQ-021.

Verification
REQ-030 DWIDTH=16, FRAME_LEN=4, m_ready=1. Stream 5,12,12,30. Required: outputs 5,7,0,18, one per cycle; m_last on 18 only.
REQ-031 Continue the stream with 100. Required: output 100, showing prev reset at the frame boundary.
REQ-032 Hold m_ready=0 for 3 cycles while s_valid=1. Required: s_ready=0, m_data held, no word lost or duplicated after release.
REQ-033 Input 0x8000 after 0x0001. Required: ovf=1; m_data=0x8000 with PSUM_DIFF_SAT_EN, 0x7FFF without.
REQ-034 Pulse clr after two words of a frame. Required: pending output dropped; next word 9 outputs 9 and the frame count restarts.
REQ-035 Assert rst_n=0 for one cycle mid-frame with m_valid=1. Required: all outputs 0 next cycle, ovf cleared, next word passes through unchanged.
